// File: rtl/vpu_pkg.sv
// Shared VPU definitions: operand width, lane count and FP driver types.
package vpu_pkg;

    localparam int OPERAND_WIDTH = 16;
    localparam int VPU_LANES     = 8;

    localparam logic [OPERAND_WIDTH-1:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUT
    } fp_drv_state_t;

endpackage

// File: rtl/vpu_fp_drv_collector.sv
// In-order result collector: lane register file plus collect index.
module vpu_fp_drv_collector
    import vpu_pkg::*;
#(
    parameter int LANES = VPU_LANES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_i,
    input  logic                           en_i,
    input  logic                           done_i,
    input  logic [OPERAND_WIDTH-1:0]       result_i,
    input  logic                           fill_i,
    output logic                           last_o,
    output logic                           all_o,
    output logic [LANES*OPERAND_WIDTH-1:0] data_o
);

    localparam int IW = $clog2(LANES + 1);
    localparam int LW = $clog2(LANES);

    logic [LANES-1:0][OPERAND_WIDTH-1:0] lane_q, lane_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic                                take;

    assign all_o  = (idx_q == IW'(LANES));
    assign take   = en_i & done_i & ~all_o;
    assign last_o = take & (idx_q == IW'(LANES - 1));
    assign data_o = lane_q;

    always_comb begin
        lane_d = lane_q;
        idx_d  = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (fill_i) begin
            // Lanes the FU never answered are poisoned with qNaN.
            for (int i = 0; i < LANES; i++) begin
                if (IW'(i) >= idx_q) lane_d[i] = BF16_QNAN;
            end
            idx_d = IW'(LANES);
        end else if (take) begin
            lane_d[idx_q[LW-1:0]] = result_i;
            idx_d                 = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            idx_q  <= '0;
        end else begin
            lane_q <= lane_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/vpu_fp_unit_driver.sv
// Streams a BF16 vector through a single-operand FP unit and regathers it.
// Define VPU_FP_DRV_TIMEOUT_EN to enable the DRAIN timeout with qNaN fill.
module vpu_fp_unit_driver
    import vpu_pkg::*;
#(
    parameter int LANES          = VPU_LANES,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           src_valid_i,
    output logic                           src_ready_o,
    input  logic [LANES*OPERAND_WIDTH-1:0] src_data_i,
    output logic                           fu_start_o,
    output logic [OPERAND_WIDTH-1:0]       fu_op_o,
    input  logic                           fu_done_i,
    input  logic [OPERAND_WIDTH-1:0]       fu_result_i,
    output logic                           dst_valid_o,
    input  logic                           dst_ready_i,
    output logic [LANES*OPERAND_WIDTH-1:0] dst_data_o,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int IW = $clog2(LANES + 1);
    localparam int LW = $clog2(LANES);

    fp_drv_state_t                       state_q, state_d;
    logic [LANES-1:0][OPERAND_WIDTH-1:0] src_q, src_d;
    logic [IW-1:0]                       issue_idx_q, issue_idx_d;
    logic                                start_q, start_d;
    logic [OPERAND_WIDTH-1:0]            op_q, op_d;
    logic                                timeout_q, timeout_d;
    logic                                clear, collect_en;
    logic                                last, all_done, tmo_hit;

    assign collect_en = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

`ifdef VPU_FP_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == ST_DRAIN) && !fu_done_i &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (state_q != ST_DRAIN || fu_done_i || tmo_hit) tmo_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    // Never fires; DRAIN waits for the FU indefinitely.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        issue_idx_d = issue_idx_q;
        start_d     = 1'b0;
        op_d        = op_q;
        timeout_d   = timeout_q;
        clear       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (src_valid_i) begin
                    src_d       = src_data_i;
                    start_d     = 1'b1;
                    op_d        = src_data_i[OPERAND_WIDTH-1:0];
                    issue_idx_d = IW'(1);
                    timeout_d   = 1'b0;
                    clear       = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The strobe-free tail cycle lets a fast FU finish in ISSUE.
                if (last) begin
                    state_d = ST_OUT;
                end else if (issue_idx_q != IW'(LANES)) begin
                    start_d     = 1'b1;
                    op_d        = src_q[issue_idx_q[LW-1:0]];
                    issue_idx_d = issue_idx_q + 1'b1;
                end else if (!start_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last || all_done) begin
                    state_d = ST_OUT;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (dst_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            issue_idx_q <= '0;
            start_q     <= 1'b0;
            op_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            issue_idx_q <= issue_idx_d;
            start_q     <= start_d;
            op_q        <= op_d;
            timeout_q   <= timeout_d;
        end
    end

    vpu_fp_drv_collector #(
        .LANES(LANES)
    ) u_collector (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (collect_en),
        .done_i  (fu_done_i),
        .result_i(fu_result_i),
        .fill_i  (tmo_hit),
        .last_o  (last),
        .all_o   (all_done),
        .data_o  (dst_data_o)
    );

    assign src_ready_o = rst_n & (state_q == ST_IDLE);
    assign fu_start_o  = start_q;
    assign fu_op_o     = op_q;
    assign dst_valid_o = (state_q == ST_OUT);
    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_vpu_fp_unit_driver.sv
// Directed bench for vpu_fp_unit_driver with a behavioural FU model.
module tb_vpu_fp_unit_driver;
    import vpu_pkg::*;

    localparam int LANES = 8;
    localparam int VW    = LANES * 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [VW-1:0] src_data = '0;
    logic          fu_start;
    logic [15:0]   fu_op;
    logic          fu_done;
    logic [15:0]   fu_result;
    logic          dst_valid;
    logic          dst_ready = 1'b0;
    logic [VW-1:0] dst_data;
    logic          busy;
    logic          timeout;

    int n_vec = 0;
    int n_err = 0;

    int          lat = 1;
    logic        exp_mode = 1'b0;
    logic [16:0] drop_ge = 17'h10000;
    logic        extra_done = 1'b0;
    logic        fu_clr = 1'b1;
    logic        pv [8];
    logic [15:0] pd [8];

    always #5 clk = ~clk;

    vpu_fp_unit_driver #(
        .LANES         (LANES),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_data_i (src_data),
        .fu_start_o (fu_start),
        .fu_op_o    (fu_op),
        .fu_done_i  (fu_done),
        .fu_result_i(fu_result),
        .dst_valid_o(dst_valid),
        .dst_ready_i(dst_ready),
        .dst_data_o (dst_data),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    function automatic logic [15:0] fexp(input logic [15:0] x);
        case (x)
            16'h0000: fexp = 16'h3F80;
            16'h3F80: fexp = 16'h402E;
            default:  fexp = 16'h7FC0;
        endcase
    endfunction

    // FU model: done appears lat cycles after the start strobe is seen.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (fu_clr) begin
                pv[i] <= 1'b0;
                pd[i] <= 16'h0000;
            end else if (i == 0) begin
                pv[0] <= fu_start;
                pd[0] <= fu_op;
            end else begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always_comb begin
        fu_done   = extra_done;
        fu_result = 16'hDEAD;
        if (!extra_done) begin
            fu_done   = pv[lat-1] && ({1'b0, pd[lat-1]} < drop_ge);
            fu_result = exp_mode ? fexp(pd[lat-1]) : pd[lat-1];
        end
    end

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [VW-1:0] v);
        @(negedge clk);
        chk("src_ready_idle", VW'(src_ready), VW'(1'b1));
        src_valid = 1'b1;
        src_data  = v;
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    // k = 0 is the first negedge after the handshake edge.
    task automatic track(output int first, output int nst,
                         output int last, output int rise);
        first = -1;
        nst   = 0;
        last  = -1;
        rise  = -1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (fu_start) begin
                if (first < 0) first = k;
                last = k;
                nst++;
            end
            if (dst_valid) begin
                rise = k;
                break;
            end
        end
    endtask

    task automatic accept();
        dst_ready = 1'b1;
        @(negedge clk);
        dst_ready = 1'b0;
        chk("valid_drop", VW'(dst_valid), VW'(1'b0));
        chk("idle_busy", VW'(busy), VW'(1'b0));
        chk("idle_ready", VW'(src_ready), VW'(1'b1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_src_ready"}, VW'(src_ready), '0);
        chk({tag, "_start"}, VW'(fu_start), '0);
        chk({tag, "_op"}, VW'(fu_op), '0);
        chk({tag, "_dst_valid"}, VW'(dst_valid), '0);
        chk({tag, "_dst_data"}, dst_data, '0);
        chk({tag, "_busy"}, VW'(busy), '0);
        chk({tag, "_timeout"}, VW'(timeout), '0);
    endtask

    initial begin
        logic [VW-1:0] vord;
        logic [VW-1:0] vexp;
        int f, n, l, r;

        vord = {16'h4080, 16'hC040, 16'h4040, 16'hC000,
                16'h4000, 16'hBF80, 16'h3F80, 16'h0000};
        vexp = {8{16'h3F80}};

        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n  = 1'b1;
        fu_clr = 1'b0;

        // Single vector, exp FU, L=4
        lat      = 4;
        exp_mode = 1'b1;
        launch('0);
        track(f, n, l, r);
        chk("t1_first_start", VW'(f), VW'(0));
        chk("t1_strobes", VW'(n), VW'(8));
        chk("t1_last_start", VW'(l), VW'(7));
        chk("t1_rise", VW'(r), VW'(12));
        chk("t1_data", dst_data, vexp);
        accept();

        // Ordering with pass-through L=1, ISSUE straight to OUT
        lat      = 1;
        exp_mode = 1'b0;
        launch(vord);
        track(f, n, l, r);
        chk("t2_strobes", VW'(n), VW'(8));
        chk("t2_rise", VW'(r), VW'(9));
        chk("t2_data", dst_data, vord);

        // Back-pressure with a stray done while in OUT
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", VW'(dst_valid), VW'(1'b1));
            chk("bp_data", dst_data, vord);
            chk("bp_src_ready", VW'(src_ready), VW'(1'b0));
            extra_done = (i == 3);
            @(negedge clk);
        end
        extra_done = 1'b0;
        accept();

        // Reset after three strobes
        lat = 6;
        launch(vord);
        repeat (2) @(negedge clk);
        chk("mid_start", VW'(fu_start), VW'(1'b1));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("late_done_busy", VW'(busy), VW'(1'b0));
        end
        lat = 1;
        launch(vord);
        track(f, n, l, r);
        chk("post_rst_rise", VW'(r), VW'(9));
        chk("post_rst_data", dst_data, vord);
        accept();

`ifdef VPU_FP_DRV_TIMEOUT_EN
        // Lanes 5..7 never answered
        lat     = 2;
        drop_ge = 17'd6;
        launch({16'h0008, 16'h0007, 16'h0006, 16'h0005,
                16'h0004, 16'h0003, 16'h0002, 16'h0001});
        track(f, n, l, r);
        chk("tmo_rise", VW'(r), VW'(25));
        chk("tmo_data", dst_data,
            {16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h0005,
             16'h0004, 16'h0003, 16'h0002, 16'h0001});
        chk("tmo_flag", VW'(timeout), VW'(1'b1));
        accept();
        chk("tmo_hold", VW'(timeout), VW'(1'b1));
        drop_ge = 17'h10000;
        lat     = 1;
        launch(vord);
        chk("tmo_clear", VW'(timeout), VW'(1'b0));
        track(f, n, l, r);
        chk("tmo_next_data", dst_data, vord);
        accept();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vpu_fp_unit_driver.md
# vpu_fp_unit_driver

Issue-side counterpart of the VPU single-operand FP function units (e.g. the FP exponent unit). It accepts one vector of LANES BF16 elements from the source port, streams the elements into the function unit one per cycle on its start/op interface, and collects the done/result stream in order. It presents the reassembled result vector to the destination port through a valid/ready handshake. It sits between VPU_SRC_PORT/VPU_CONTROLLER and the FU on one side, and VPU_DST_PORT on the other.

## Interface
Parameters:
- LANES, 8, elements per vector; must be ≥ 2.
- TIMEOUT_CYCLES, 64, maximum cycles between FU results before timeout (used only with the timeout feature).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_valid_i  in  1  source vector valid.
- src_ready_o  out  1  driver can accept a vector.
- src_data_i  in  LANES*OPERAND_WIDTH  operand vector; lane i occupies bits [16i+15:16i].
- fu_start_o  out  1  one-cycle issue strobe to the FU (start_i).
- fu_op_o  out  OPERAND_WIDTH  operand to the FU (op_0).
- fu_done_i  in  1  FU result valid (done_o).
- fu_result_i  in  OPERAND_WIDTH  FU result (result_o).
- dst_valid_o  out  1  result vector valid.
- dst_ready_i  in  1  destination accepts the vector.
- dst_data_o  out  LANES*OPERAND_WIDTH  result vector; same lane packing as src_data_i.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  sticky timeout error for the current vector.

OPERAND_WIDTH = 16 comes from VPU_PKG.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, OUT. Reset state is IDLE.
- **IDLE**
  - src_ready_o = 1.
  - On src_valid_i: latch src_data_i, clear issue_idx, collect_idx and timeout_o, then go to ISSUE.
- **ISSUE**
  - Each cycle, drive the registered outputs fu_start_o = 1 and fu_op_o = lane[issue_idx], then increment issue_idx.
  - After issuing lane LANES-1, go to DRAIN. The next cycle has fu_start_o = 0.
  - There is no back-pressure toward the FU. Exactly LANES strobes are issued per vector, back-to-back.
- **Collection (ISSUE and DRAIN)**
  - Each cycle with fu_done_i = 1: write fu_result_i to the result lane [collect_idx], then increment collect_idx.
  - Results can arrive while ISSUE is still active, because FU latency may be shorter than LANES.
- **DRAIN**
  - When the LANES-th result is written, go to OUT.
  - If that result arrives in the last ISSUE cycle, go straight from ISSUE to OUT.
- **OUT**
  - dst_valid_o = 1 and dst_data_o is stable.
  - On dst_ready_i, go to IDLE.
  - A new vector is not accepted in the same cycle as the dst handshake (src_ready_o is 0 in OUT).
- fu_done_i in IDLE or OUT is ignored. collect_idx never exceeds LANES.
- Counter widths: issue_idx and collect_idx are $clog2(LANES+1) bits.
- **Reset mid-operation:** everything returns to IDLE immediately. FU results still in flight are later ignored in IDLE.

## Timing
- Reset values: src_ready_o 0 while rst_n is low and 1 after release (IDLE); fu_start_o 0; fu_op_o 0; dst_valid_o 0; dst_data_o 0; busy_o 0; timeout_o 0.
- First fu_start_o is one cycle after the src handshake; strobes are then contiguous for LANES cycles.
- With FU latency L (start to done), dst_valid_o rises L+LANES cycles after the src handshake cycle.
- dst_valid_o stays high until the cycle dst_ready_i is sampled high. It drops the next cycle.

## Configuration
- Macro: VPU_FP_DRV_TIMEOUT_EN.
- **Defined:**
  - A counter runs in DRAIN. It clears on each fu_done_i and on entry to DRAIN.
  - When it reaches TIMEOUT_CYCLES: write 16'h7FC0 (BF16 qNaN) to every uncollected lane, set timeout_o, and go to OUT.
  - timeout_o holds until the next src handshake.
- **Undefined:**
  - No counter; DRAIN waits indefinitely.
  - timeout_o is tied to 0; the port remains.

## Structure
- Add to VPU_PKG:
  - the FSM state enum type (fp_drv_state_t);
  - the constant BF16_QNAN = 16'h7FC0;
  - LANES default constant VPU_LANES.
- Single sub-module: vpu_fp_drv_collector.
  - Contains the result lane register file, collect_idx and the all-collected flag.
  - The top holds the FSM, the issue path and the timeout counter.

## Test plan
- **Single vector:** FU model returns exp with L=4; input all lanes 16'h0000 → 8 strobes in consecutive cycles. dst_data_o has all lanes 16'h3F80, and dst_valid_o rises 12 cycles after the handshake.
- **Ordering:** lanes 0..7 = 16'h0000, 16'h3F80 (1.0), 16'hBF80 (-1.0), … with a pass-through FU (L=1) → dst lanes equal src lanes, in the same order.
- **Back-pressure:** dst_ready_i held low for 10 cycles → dst_valid_o and dst_data_o stable, src_ready_o 0; accepted on the first high cycle, IDLE the next.
- **Short latency L=1** → results collected during ISSUE; transition goes ISSUE→OUT with no DRAIN cycle.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):** FU drops the done for lane 5 onward → after 16 idle DRAIN cycles, lanes 5–7 read 16'h7FC0, timeout_o = 1, dst_valid_o = 1.
- **Reset mid-ISSUE (after 3 strobes):** all outputs take their reset values. Late fu_done_i pulses after release do not change state, and the next vector completes correctly.
